// File: rtl/tempsense_pkg.sv
// -----------------------------------------------------------------------------
// tempsense_pkg
// Shared declarations for the tempsense SAR sequencer:
//   - sar_state_t : sequencer state encoding
//   - vmax/vmin   : extreme DAC codes for an N-bit DAC
//   - cnt_width   : width of the shared PRECHARGE/MEASURE cycle counter
// -----------------------------------------------------------------------------
package tempsense_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRECHARGE  = 3'd1,
        ST_TRANSITION = 3'd2,
        ST_MEASURE    = 3'd3,
        ST_DECIDE     = 3'd4,
        ST_DONE       = 3'd5
    } sar_state_t;

    // Highest DAC code: all N bits set.
    function automatic int vmax(input int n_vdac);
        return (1 << n_vdac) - 1;
    endfunction

    // Lowest DAC code: all N bits clear, independent of width.
    function automatic int vmin(input int n_vdac);
        return 0 * n_vdac;
    endfunction

    // Counter must hold 0 .. max(t_pre, t_meas)-1; never narrower than 1 bit.
    function automatic int cnt_width(input int t_pre, input int t_meas);
        int longest;
        longest = (t_pre > t_meas) ? t_pre : t_meas;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage : tempsense_pkg

// File: rtl/tempsense_sync2.sv
// -----------------------------------------------------------------------------
// tempsense_sync2
// Two-flop synchronizer for the asynchronous delay-cell output.
// Ports:
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset (flops clear to 0)
//   d       in  asynchronous input
//   q       out synchronized output, two clk cycles behind d
// -----------------------------------------------------------------------------
module tempsense_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule : tempsense_sync2

// File: rtl/tempsense_sar_ctrl.sv
// -----------------------------------------------------------------------------
// tempsense_sar_ctrl
// Successive-approximation sequencer for the tempsense delay cell. Each
// conversion runs one trial per DAC bit, MSB first; every trial is
// PRECHARGE (T_PRE) -> TRANSITION (1) -> MEASURE (T_MEAS) -> DECIDE (1).
// A trial whose delay completes inside the measure window ("pass") clears
// the bit under test, so the search ends on the largest code that still
// fails, i.e. threshold-1 clamped to 0..VMAX.
//
// Ports:
//   clk               in   system clock
//   reset_n           in   asynchronous active-low reset
//   enable            in   level enable; low aborts to IDLE and drops tempsens_en
//   start             in   one-cycle conversion request (honoured in IDLE only)
//   continuous        in   auto-restart after every DONE while high
//   temp_delay        in   raw asynchronous delay-cell output
//   tempsens_dat      out  DAC code to the cell
//   tempsens_en       out  DAC enable to the cell (registered enable)
//   tempsens_measure  out  cell precharge_n (0 = precharge)
//   busy              out  high from first PRECHARGE through last DECIDE
//   in_measurement    out  high during MEASURE
//   result            out  last completed conversion result
//   result_valid      out  one-cycle pulse, coincident with a new result
// -----------------------------------------------------------------------------
module tempsense_sar_ctrl
    import tempsense_pkg::*;
#(
    parameter int N_VDAC = 6,
    parameter int T_PRE  = 4,
    parameter int T_MEAS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              start,
    input  logic              continuous,
    input  logic              temp_delay,
    output logic [N_VDAC-1:0] tempsens_dat,
    output logic              tempsens_en,
    output logic              tempsens_measure,
    output logic              busy,
    output logic              in_measurement,
    output logic [N_VDAC-1:0] result,
    output logic              result_valid
);

    localparam int CNT_W = cnt_width(T_PRE, T_MEAS);
    localparam int IDX_W = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;

    localparam logic [N_VDAC-1:0] CODE_VMAX = N_VDAC'(vmax(N_VDAC));
    localparam logic [N_VDAC-1:0] CODE_VMIN = N_VDAC'(vmin(N_VDAC));
    localparam logic [N_VDAC-1:0] CODE_MSB  = N_VDAC'(1) << (N_VDAC - 1);
    localparam logic [IDX_W-1:0]  IDX_MSB   = IDX_W'(N_VDAC - 1);
    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(T_PRE - 1);
    localparam logic [CNT_W-1:0]  MEAS_LAST = CNT_W'(T_MEAS - 1);

    // Parameter sanity: the synchronizer needs at least 3 measure cycles to
    // deliver a sample taken while the cell was actually being measured.
    generate
        if (T_MEAS < 3) begin : g_bad_t_meas
            $error("tempsense_sar_ctrl: T_MEAS must be >= 3");
        end
        if (T_PRE < 1) begin : g_bad_t_pre
            $error("tempsense_sar_ctrl: T_PRE must be >= 1");
        end
        if (N_VDAC < 1) begin : g_bad_n_vdac
            $error("tempsense_sar_ctrl: N_VDAC must be >= 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Synchronized cell output
    // -------------------------------------------------------------------------
    logic delay_sync;

    tempsense_sync2 u_sync2 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (temp_delay),
        .q       (delay_sync)
    );

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    sar_state_t        state_reg,  state_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic [N_VDAC-1:0] code_reg,   code_next;
    logic [IDX_W-1:0]  idx_reg,    idx_next;
    logic              pass_reg,   pass_next;
    logic [N_VDAC-1:0] result_reg, result_next;

    // Registered cell/status outputs, decoded from the next state so they
    // change cleanly on the clock edge rather than through decode glitches.
    logic [N_VDAC-1:0] dat_reg,     dat_next;
    logic              meas_reg,    meas_next;
    logic              busy_reg,    busy_next;
    logic              inmeas_reg,  inmeas_next;
    logic              valid_reg,   valid_next;
    logic              en_reg;

    // One-hot masks: bit under test, and the next-lower bit to try next.
    logic [N_VDAC-1:0] bit_mask;
    logic [N_VDAC-1:0] lower_mask;

    genvar gi;
    generate
        for (gi = 0; gi < N_VDAC; gi++) begin : g_mask
            assign bit_mask[gi]   = (int'(idx_reg) == gi);
            assign lower_mask[gi] = (int'(idx_reg) == gi + 1);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic [N_VDAC-1:0] code_decided;

    always_comb begin
        state_next   = state_reg;
        code_next    = code_reg;
        idx_next     = idx_reg;
        pass_next    = pass_reg;
        result_next  = result_reg;
        // A passing trial means the threshold is at or below this code.
        code_decided = pass_reg ? (code_reg & ~bit_mask) : code_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start || continuous) begin
                    state_next = ST_PRECHARGE;
                    code_next  = CODE_MSB;
                    idx_next   = IDX_MSB;
                end
            end
            ST_PRECHARGE: begin
                if (cnt_reg == PRE_LAST) begin
                    state_next = ST_TRANSITION;
                end
            end
            ST_TRANSITION: begin
                state_next = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (cnt_reg == MEAS_LAST) begin
                    state_next = ST_DECIDE;
                    pass_next  = delay_sync;
                end
            end
            ST_DECIDE: begin
                if (idx_reg != '0) begin
                    state_next = ST_PRECHARGE;
                    code_next  = code_decided | lower_mask;
                    idx_next   = idx_reg - 1'b1;
                end else begin
                    // Result is published on entry to DONE so that it lines
                    // up with the result_valid pulse.
                    state_next  = ST_DONE;
                    code_next   = code_decided;
                    result_next = code_decided;
                end
            end
            ST_DONE: begin
                if (continuous) begin
                    state_next = ST_PRECHARGE;
                    code_next  = CODE_MSB;
                    idx_next   = IDX_MSB;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Losing enable discards the conversion in progress, including a
        // result that would otherwise be published this cycle.
        if (!enable) begin
            state_next  = ST_IDLE;
            code_next   = '0;
            idx_next    = IDX_MSB;
            result_next = result_reg;
        end
    end

    // Shared counter: restarts on every state change, runs only where it is
    // used for the phase length.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (state_reg == ST_PRECHARGE || state_reg == ST_MEASURE) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Output decode for the cycle being entered.
    always_comb begin
        dat_next    = CODE_VMAX;
        meas_next   = 1'b0;
        busy_next   = 1'b0;
        inmeas_next = 1'b0;
        valid_next  = 1'b0;
        case (state_next)
            ST_PRECHARGE: begin
                busy_next = 1'b1;
            end
            ST_TRANSITION: begin
                dat_next  = CODE_VMIN;
                busy_next = 1'b1;
            end
            ST_MEASURE: begin
                dat_next    = code_next;
                meas_next   = 1'b1;
                busy_next   = 1'b1;
                inmeas_next = 1'b1;
            end
            ST_DECIDE: begin
                dat_next  = code_next;
                meas_next = 1'b1;
                busy_next = 1'b1;
            end
            ST_DONE: begin
                valid_next = 1'b1;
            end
            default: begin
                dat_next = CODE_VMAX;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            code_reg   <= '0;
            idx_reg    <= IDX_MSB;
            pass_reg   <= 1'b0;
            result_reg <= '0;
            dat_reg    <= CODE_VMAX;
            meas_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            inmeas_reg <= 1'b0;
            valid_reg  <= 1'b0;
            en_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            code_reg   <= code_next;
            idx_reg    <= idx_next;
            pass_reg   <= pass_next;
            result_reg <= result_next;
            dat_reg    <= dat_next;
            meas_reg   <= meas_next;
            busy_reg   <= busy_next;
            inmeas_reg <= inmeas_next;
            valid_reg  <= valid_next;
            en_reg     <= enable;
        end
    end

    assign tempsens_dat     = dat_reg;
    assign tempsens_en      = en_reg;
    assign tempsens_measure = meas_reg;
    assign busy             = busy_reg;
    assign in_measurement   = inmeas_reg;
    assign result           = result_reg;
    assign result_valid     = valid_reg;

endmodule : tempsense_sar_ctrl

// File: tb/tb_tempsense_sar_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tempsense_sar_ctrl
// Drives a threshold delay-cell model (temp_delay = measure && dat >= threshold)
// and checks every cycle against a conversion-timeline model, plus directed
// literal expectations per scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tempsense_sar_ctrl;

    localparam int N_VDAC = 6;
    localparam int T_PRE  = 4;
    localparam int T_MEAS = 8;
    localparam int VMAX   = (1 << N_VDAC) - 1;
    localparam int TRIAL  = T_PRE + T_MEAS + 2;   // 14
    localparam int CONV   = N_VDAC * TRIAL;       // 84

    logic clk        = 1'b0;
    logic reset_n    = 1'b0;
    logic enable     = 1'b0;
    logic start      = 1'b0;
    logic continuous = 1'b0;
    logic temp_delay;
    logic [N_VDAC-1:0] tempsens_dat;
    logic tempsens_en;
    logic tempsens_measure;
    logic busy;
    logic in_measurement;
    logic [N_VDAC-1:0] result;
    logic result_valid;

    int threshold = 37;

    always #5 clk = ~clk;

    // Monotonic delay cell: completes in time whenever the code is at or
    // above its threshold, and only while it is being measured.
    assign temp_delay = tempsens_measure && (int'(tempsens_dat) >= threshold);

    tempsense_sar_ctrl #(
        .N_VDAC (N_VDAC),
        .T_PRE  (T_PRE),
        .T_MEAS (T_MEAS)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .start            (start),
        .continuous       (continuous),
        .temp_delay       (temp_delay),
        .tempsens_dat     (tempsens_dat),
        .tempsens_en      (tempsens_en),
        .tempsens_measure (tempsens_measure),
        .busy             (busy),
        .in_measurement   (in_measurement),
        .result           (result),
        .result_valid     (result_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference arithmetic
    // ---------------------------------------------------------------------
    function automatic int exp_result(input int th);
        if (th <= 0)   return 0;
        if (th > VMAX) return VMAX;
        return th - 1;
    endfunction

    // With a monotonic cell every decided bit already equals the final
    // result bit, so trial t tries result's top t bits plus the bit under test.
    function automatic int exp_code(input int th, input int t);
        int r;
        int low;
        r   = exp_result(th);
        low = 1 << (N_VDAC - t);
        return (r & ~(low - 1)) | (1 << (N_VDAC - 1 - t));
    endfunction

    // ---------------------------------------------------------------------
    // Per-cycle timeline model and compare process.
    // m_k: 0 = idle, 1..CONV = trial cycles, CONV+1 = DONE.
    // ---------------------------------------------------------------------
    int m_k      = 0;
    int m_th     = 0;
    int m_result = 0;
    int m_en     = 0;

    always @(negedge clk) begin
        int e_dat, e_meas, e_busy, e_inm, e_valid, t, p, k_next;
        if (!reset_n) begin
            chk("rst_dat",   32'(tempsens_dat), VMAX);
            chk("rst_meas",  32'(tempsens_measure), 0);
            chk("rst_busy",  32'(busy), 0);
            chk("rst_res",   32'(result), 0);
            chk("rst_valid", 32'(result_valid), 0);
            chk("rst_en",    32'(tempsens_en), 0);
            m_k      = 0;
            m_result = 0;
            m_en     = 0;
        end else begin
            e_dat = VMAX; e_meas = 0; e_busy = 0; e_inm = 0; e_valid = 0;
            if (m_k >= 1 && m_k <= CONV) begin
                t = (m_k - 1) / TRIAL;
                p = (m_k - 1) % TRIAL;
                e_busy = 1;
                if (p < T_PRE) begin
                    e_dat = VMAX;
                end else if (p == T_PRE) begin
                    e_dat = 0;
                end else begin
                    e_dat  = exp_code(m_th, t);
                    e_meas = 1;
                    e_inm  = (p < T_PRE + 1 + T_MEAS) ? 1 : 0;
                end
            end else if (m_k == CONV + 1) begin
                e_valid = 1;
            end
            chk("dat",   32'(tempsens_dat), e_dat);
            chk("meas",  32'(tempsens_measure), e_meas);
            chk("busy",  32'(busy), e_busy);
            chk("inm",   32'(in_measurement), e_inm);
            chk("valid", 32'(result_valid), e_valid);
            chk("res",   32'(result), m_result);
            chk("en",    32'(tempsens_en), m_en);

            if (!enable) begin
                k_next = 0;
            end else if (m_k == 0) begin
                k_next = (start || continuous) ? 1 : 0;
            end else if (m_k <= CONV) begin
                k_next = m_k + 1;
            end else begin
                k_next = continuous ? 1 : 0;
            end
            if (k_next == 1) m_th = threshold;
            if (k_next == CONV + 1) m_result = exp_result(m_th);
            m_en = enable ? 1 : 0;
            m_k  = k_next;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    int obs_codes[$];
    int obs_valid_at[$];
    int obs_res[$];
    int obs_dat[$];
    int obs_meas[$];
    int obs_inm[$];
    int obs_busy_first, obs_busy_last, obs_busy_cnt;
    int obs_en_after_abort;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench at cycle 0 of a conversion with start asserted.
    task automatic begin_conv(input int th, input logic cont);
        tick(2);
        threshold  = th;
        continuous = cont;
        start      = 1'b1;
    endtask

    // Observes cycles 1..ncyc after the start cycle, sampling 1 ns after each
    // edge; optional hooks abort, re-start, drop continuous, retarget threshold.
    task automatic observe(input int ncyc, input int abort_at, input int extra_start_at,
                           input int drop_cont_at, input int new_th);
        int prev_inm;
        prev_inm = 0;
        obs_codes.delete(); obs_valid_at.delete(); obs_res.delete();
        obs_dat.delete(); obs_meas.delete(); obs_inm.delete();
        obs_busy_first = -1; obs_busy_last = -1; obs_busy_cnt = 0;
        obs_en_after_abort = -1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            start = (k == extra_start_at) ? 1'b1 : 1'b0;
            if (k == abort_at) enable = 1'b0;
            if (k == drop_cont_at) continuous = 1'b0;
            if (abort_at >= 0 && k == abort_at + 1) obs_en_after_abort = int'(tempsens_en);
            obs_dat.push_back(int'(tempsens_dat));
            obs_meas.push_back(int'(tempsens_measure));
            obs_inm.push_back(int'(in_measurement));
            if (busy) begin
                if (obs_busy_first < 0) obs_busy_first = k;
                obs_busy_last = k;
                obs_busy_cnt++;
            end
            if (in_measurement && prev_inm == 0) obs_codes.push_back(int'(tempsens_dat));
            prev_inm = int'(in_measurement);
            if (result_valid) begin
                obs_valid_at.push_back(k);
                obs_res.push_back(int'(result));
                $display("conversion: threshold=%0d result=%0d valid_at=%0d", threshold, result, k);
                if (new_th >= 0) threshold = new_th;
            end
        end
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    initial begin
        int ed, em, ei;
        int lit_codes[6];
        lit_codes = '{32, 48, 40, 36, 38, 37};

        // Reset state
        tick(3);
        chk("reset_dat", 32'(tempsens_dat), 63);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_result", 32'(result), 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        tick(3);

        // Threshold 37
        begin_conv(37, 1'b0);
        observe(95, -1, -1, -1, -1);
        chk("t37_ncodes", 32'(obs_codes.size()), 6);
        for (int i = 0; i < 6 && i < obs_codes.size(); i++)
            chk("t37_code", 32'(obs_codes[i]), lit_codes[i]);
        chk("t37_nvalid", 32'(obs_valid_at.size()), 1);
        if (obs_valid_at.size() > 0) begin
            chk("t37_valid_at", 32'(obs_valid_at[0]), 85);
            chk("t37_result", 32'(obs_res[0]), 36);
        end
        chk("t37_busy_first", 32'(obs_busy_first), 1);
        chk("t37_busy_last", 32'(obs_busy_last), 84);
        chk("t37_busy_cnt", 32'(obs_busy_cnt), 84);
        chk("t37_model_result", 32'(exp_result(37)), 36);

        // Phase check on trial 0 (code 32)
        for (int k = 1; k <= 14; k++) begin
            ed = (k <= 4) ? 63 : ((k == 5) ? 0 : 32);
            em = (k >= 6) ? 1 : 0;
            ei = (k >= 6 && k <= 13) ? 1 : 0;
            chk("phase_dat", 32'(obs_dat[k-1]), ed);
            chk("phase_meas", 32'(obs_meas[k-1]), em);
            chk("phase_inm", 32'(obs_inm[k-1]), ei);
        end

        // Extremes
        begin_conv(0, 1'b0);
        observe(90, -1, -1, -1, -1);
        chk("th0_nvalid", 32'(obs_valid_at.size()), 1);
        if (obs_res.size() > 0) chk("th0_result", 32'(obs_res[0]), 0);
        begin_conv(64, 1'b0);
        observe(90, -1, -1, -1, -1);
        chk("th64_nvalid", 32'(obs_valid_at.size()), 1);
        if (obs_res.size() > 0) chk("th64_result", 32'(obs_res[0]), 63);

        // Abort by enable at cycle 30
        begin_conv(37, 1'b0);
        observe(95, 30, -1, -1, -1);
        chk("abort_busy_last", 32'(obs_busy_last), 30);
        chk("abort_nvalid", 32'(obs_valid_at.size()), 0);
        chk("abort_result", 32'(result), 63);
        chk("abort_en", 32'(obs_en_after_abort), 0);
        enable = 1'b1;
        tick(2);

        // Start while busy is ignored
        begin_conv(10, 1'b0);
        observe(95, -1, 20, -1, -1);
        chk("busystart_nvalid", 32'(obs_valid_at.size()), 1);
        if (obs_valid_at.size() > 0) begin
            chk("busystart_valid_at", 32'(obs_valid_at[0]), 85);
            chk("busystart_result", 32'(obs_res[0]), 9);
        end

        // Continuous: 20 then 45, continuous dropped during the second run
        begin_conv(20, 1'b1);
        observe(180, -1, -1, 100, 45);
        chk("cont_nvalid", 32'(obs_valid_at.size()), 2);
        if (obs_valid_at.size() == 2) begin
            chk("cont_res0", 32'(obs_res[0]), 19);
            chk("cont_res1", 32'(obs_res[1]), 44);
            chk("cont_spacing", 32'(obs_valid_at[1] - obs_valid_at[0]), 85);
        end
        chk("cont_busy_cnt", 32'(obs_busy_cnt), 168);
        chk("cont_busy_last", 32'(obs_busy_last), 169);

        // Reset mid-conversion at cycle 40
        begin_conv(37, 1'b0);
        observe(39, -1, -1, -1, -1);
        chk("pre_reset_busy", 32'(busy), 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_dat", 32'(tempsens_dat), 63);
        chk("arst_meas", 32'(tempsens_measure), 0);
        chk("arst_inm", 32'(in_measurement), 0);
        chk("arst_result", 32'(result), 0);
        chk("arst_valid", 32'(result_valid), 0);
        chk("arst_en", 32'(tempsens_en), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(2);
        begin_conv(37, 1'b0);
        observe(90, -1, -1, -1, -1);
        chk("post_rst_nvalid", 32'(obs_valid_at.size()), 1);
        if (obs_valid_at.size() > 0) begin
            chk("post_rst_valid_at", 32'(obs_valid_at[0]), 85);
            chk("post_rst_result", 32'(obs_res[0]), 36);
        end

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tempsense_sar_ctrl
